// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with a one-entry response register. Optional grant lock: define ALU_ARB_LOCK_EN.

package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opcode_e;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid_ip,
    output logic [NUM_REQ-1:0]                req_ready_op,
    input  alu_opcode_e [NUM_REQ-1:0]         req_operator_ip,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      req_operand_a_ip,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      req_operand_b_ip,
    input  logic [NUM_REQ-1:0]                req_lock_ip,
    output logic                              alu_enable_op,
    output alu_opcode_e                       alu_operator_op,
    output logic [XLEN-1:0]                   alu_operand_a_op,
    output logic [XLEN-1:0]                   alu_operand_b_op,
    input  logic [XLEN-1:0]                   alu_result_ip,
    input  logic                              alu_valid_ip,
    output logic                              rsp_valid_op,
    input  logic                              rsp_ready_ip,
    output logic [XLEN-1:0]                   rsp_result_op,
    output logic [ID_W-1:0]                   rsp_id_op,
    output logic                              rsp_error_op
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_next;
    logic [ID_W-1:0]   grant_idx, hi_idx, lo_idx;
    logic              hi_found, lo_found, grant_valid;
    logic              can_issue, xfer;
    logic [NUM_REQ-1:0] lock_mask, eligible;

`ifdef ALU_ARB_LOCK_EN
    logic            lock_q;
    logic [ID_W-1:0] lock_owner_q;

    // While locked only the owner is eligible for a grant
    assign lock_mask = lock_q ? (NUM_REQ'(1) << lock_owner_q) : '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
        end else if (xfer) begin
            lock_q       <= req_lock_ip[grant_idx];
            lock_owner_q <= grant_idx;
        end
    end
`else
    logic unused_lock;
    assign lock_mask   = '1;
    assign unused_lock = ^req_lock_ip;
`endif

    assign eligible = req_valid_ip & lock_mask;

    // Lowest eligible index at/above rr_ptr, else lowest eligible index overall
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(j);
                if (ID_W'(j) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
            end
        end
        grant_valid = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Response FSM next state, grant handshake and ALU drive
    always_comb begin
        state_d          = state_q;
        req_ready_op     = '0;
        alu_enable_op    = 1'b0;
        alu_operator_op  = ALU_ADD;
        alu_operand_a_op = '0;
        alu_operand_b_op = '0;
        can_issue        = (state_q == EMPTY) || rsp_ready_ip;
        xfer             = can_issue && grant_valid;
        if (xfer) begin
            req_ready_op     = NUM_REQ'(1) << grant_idx;
            alu_enable_op    = 1'b1;
            alu_operator_op  = req_operator_ip[grant_idx];
            alu_operand_a_op = req_operand_a_ip[grant_idx];
            alu_operand_b_op = req_operand_b_ip[grant_idx];
            state_d          = FULL;
        end else if ((state_q == FULL) && rsp_ready_ip) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= EMPTY;
            rr_ptr_q      <= '0;
            rsp_result_op <= '0;
            rsp_id_op     <= '0;
            rsp_error_op  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                rr_ptr_q      <= rr_ptr_next;
                rsp_result_op <= alu_result_ip;
                rsp_id_op     <= grant_idx;
                rsp_error_op  <= ~alu_valid_ip;
            end
        end
    end

    assign rsp_valid_op = (state_q == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a per-cycle
// compare against a transaction-level reference model (lock-aware when ALU_ARB_LOCK_EN).

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int XL = 32;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b0;
    logic [NR-1:0]         req_valid = '0;
    logic [NR-1:0]         req_ready;
    alu_opcode_e [NR-1:0]  req_op;
    logic [NR-1:0][XL-1:0] req_a = '0;
    logic [NR-1:0][XL-1:0] req_b = '0;
    logic [NR-1:0]         req_lock = '0;
    logic                  alu_en;
    alu_opcode_e           alu_op;
    logic [XL-1:0]         alu_a, alu_b, alu_result;
    logic                  alu_valid;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [XL-1:0]         rsp_result;
    logic                  rsp_id;
    logic                  rsp_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NR), .XLEN(XL)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_ip     (req_valid),
        .req_ready_op     (req_ready),
        .req_operator_ip  (req_op),
        .req_operand_a_ip (req_a),
        .req_operand_b_ip (req_b),
        .req_lock_ip      (req_lock),
        .alu_enable_op    (alu_en),
        .alu_operator_op  (alu_op),
        .alu_operand_a_op (alu_a),
        .alu_operand_b_op (alu_b),
        .alu_result_ip    (alu_result),
        .alu_valid_ip     (alu_valid),
        .rsp_valid_op     (rsp_valid),
        .rsp_ready_ip     (rsp_ready),
        .rsp_result_op    (rsp_result),
        .rsp_id_op        (rsp_id),
        .rsp_error_op     (rsp_error)
    );

    // Minimal ALU: only ADD/SUB/XOR/OR/AND are implemented, anything else is unsupported
    function automatic logic [XL-1:0] alu_res(input alu_opcode_e op, input logic [XL-1:0] a, input logic [XL-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic logic alu_ok(input alu_opcode_e op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_XOR) || (op == ALU_OR) || (op == ALU_AND);
    endfunction

    assign alu_result = alu_res(alu_op, alu_a, alu_b);
    assign alu_valid  = alu_ok(alu_op);

    // Reference model state: response slot, round-robin start point, lock
    logic          m_v      = 1'b0;
    logic [XL-1:0] m_res    = '0;
    int            m_id     = 0;
    logic          m_err    = 1'b0;
    int            m_rr     = 0;
    logic          m_locked = 1'b0;
    int            m_owner  = 0;
    int            m_grant;

    function automatic int grant_of(input logic v, input logic rdy, input int rr, input logic locked,
                                    input int owner, input logic [NR-1:0] valid);
        if (v && !rdy) return -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr + k) % NR;
            if (valid[idx] && (!locked || idx == owner)) return idx;
        end
        return -1;
    endfunction

    assign m_grant = grant_of(m_v, rsp_ready, m_rr, m_locked, m_owner, req_valid);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v      <= 1'b0;
            m_res    <= '0;
            m_id     <= 0;
            m_err    <= 1'b0;
            m_rr     <= 0;
            m_locked <= 1'b0;
            m_owner  <= 0;
        end else if (m_grant >= 0) begin
            m_v   <= 1'b1;
            m_res <= alu_res(req_op[m_grant], req_a[m_grant], req_b[m_grant]);
            m_err <= !alu_ok(req_op[m_grant]);
            m_id  <= m_grant;
            m_rr  <= (m_grant + 1) % NR;
`ifdef ALU_ARB_LOCK_EN
            m_locked <= req_lock[m_grant];
            m_owner  <= m_grant;
`endif
        end else if (m_v && rsp_ready) begin
            m_v <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle while inputs are stable
    logic [NR-1:0] exp_ready;
    always @(negedge clk) begin
        exp_ready = (m_grant >= 0) ? (NR'(1) << m_grant) : '0;
        check("cmp_req_ready", 32'(req_ready), 32'(exp_ready));
        check("cmp_alu_enable", 32'(alu_en), 32'(m_grant >= 0));
        if (m_grant >= 0) begin
            check("cmp_alu_op", 32'(alu_op), 32'(req_op[m_grant]));
            check("cmp_alu_a", alu_a, req_a[m_grant]);
            check("cmp_alu_b", alu_b, req_b[m_grant]);
        end else begin
            check("cmp_alu_op_idle", 32'(alu_op), 32'(ALU_ADD));
            check("cmp_alu_a_idle", alu_a, 32'd0);
            check("cmp_alu_b_idle", alu_b, 32'd0);
        end
        check("cmp_rsp_valid", 32'(rsp_valid), 32'(m_v));
        if (m_v) begin
            check("cmp_rsp_result", rsp_result, m_res);
            check("cmp_rsp_id", 32'(rsp_id), 32'(m_id));
            check("cmp_rsp_error", 32'(rsp_error), 32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input alu_opcode_e op,
                           input logic [XL-1:0] a, input logic [XL-1:0] b, input logic lk);
        req_valid[i] = v;
        req_op[i]    = op;
        req_a[i]     = a;
        req_b[i]     = b;
        req_lock[i]  = lk;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, ALU_ADD, '0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        step();
        reset = 1'b1;
        clear_reqs();
        step();
        reset = 1'b0;
    endtask

    logic [NR-1:0] exp6 [5];
    int n1;

    initial begin
        clear_reqs();
        #1 reset = 1'b1;
        step();
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        step();
        reset = 1'b0;

        // Single op: ADD 5+7 from req0
        rsp_ready = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0);
        #1 check("t1_ready", 32'(req_ready), 32'h1);
        step();
        clear_reqs();
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_result", rsp_result, 32'd12);
        check("t1_id", 32'(rsp_id), 32'd0);
        check("t1_error", 32'(rsp_error), 32'd0);

        // Contention: grants alternate 0,1,0,1
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, ALU_SUB, 32'd10, 32'd3, 1'b0);
        set_req(1, 1'b1, ALU_XOR, 32'hF0, 32'h0F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 check("t2_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check("t2_result", rsp_result, (i % 2 == 0) ? 32'd7 : 32'hFF);
            check("t2_id", 32'(rsp_id), 32'(i % 2));
        end
        clear_reqs();

        // Backpressure: response held for 5 cycles, then drain+issue
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
        step();
        rsp_ready = 1'b0;
        set_req(0, 1'b1, ALU_ADD, 32'd4, 32'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_ready_blocked", 32'(req_ready), 32'h0);
            check("t3_rsp_held_valid", 32'(rsp_valid), 32'd1);
            check("t3_rsp_held_result", rsp_result, 32'd3);
            step();
        end
        rsp_ready = 1'b1;
        #1 check("t3_ready_resume", 32'(req_ready), 32'h1);
        step();
        clear_reqs();
        #1;
        check("t3_drain_issue_valid", 32'(rsp_valid), 32'd1);
        check("t3_drain_issue_result", rsp_result, 32'd8);
        step();
        check("t3_drained", 32'(rsp_valid), 32'd0);

        // Unsupported operator from req1 reports an error; next grant to req0
        apply_reset();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, ALU_SLTU, 32'd3, 32'd9, 1'b0);
        #1 check("t4_ready", 32'(req_ready), 32'h2);
        step();
        clear_reqs();
        #1;
        check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t4_id", 32'(rsp_id), 32'd1);
        check("t4_error", 32'(rsp_error), 32'd1);
        check("t4_result", rsp_result, 32'd0);
        set_req(0, 1'b1, ALU_ADD, 32'd2, 32'd2, 1'b0);
        set_req(1, 1'b1, ALU_ADD, 32'd3, 32'd3, 1'b0);
        #1 check("t4_next_grant", 32'(req_ready), 32'h1);
        step();
        clear_reqs();
        step();

        // Async reset while the response slot is full
        apply_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0);
        set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2, 1'b0);
        step();
        step();
        rsp_ready = 1'b0;
        #1 check("t5_full_before", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1 check("t5_async_clear", 32'(rsp_valid), 32'd0);
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
        check("t5_first_grant", 32'(req_ready), 32'h1);
        step();
        clear_reqs();
        #1;
        check("t5_id", 32'(rsp_id), 32'd0);
        check("t5_result", rsp_result, 32'd2);
        step();

        // Lock: req1 issues three ops with lock 1,1,0 while req0 keeps requesting
`ifdef ALU_ARB_LOCK_EN
        exp6 = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
`else
        exp6 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
        apply_reset();
        rsp_ready = 1'b1;
        n1 = 0;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0);
        set_req(1, 1'b1, ALU_OR, 32'h10, 32'h01, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1 check("t6_grant", 32'(req_ready), 32'(exp6[c]));
            step();
            if (exp6[c] == 2'b10) begin
                n1++;
                req_lock[1] = (n1 < 2);
            end
        end
        clear_reqs();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
